dispatcher: RTL and testbench
=============================

DISPATCHER -- requirements
Module: dispatcher

Interface
REQ-001 Parameters: none; widths SHALL come from defines.v (`DATA_TYPE` 32b, `ADDR_TYPE` 32b, `ROB_ID_TYPE`, `OPENUM_TYPE`); ROB id 0 (`ZERO_ROB`) SHALL mean "no dependency".
REQ-002 clk  in  1  system clock; single clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ena_from_if  in  1  decoded instruction valid this cycle.
REQ-005 openum_from_dec  in  OPENUM; rd/rs1/rs2_from_dec  in  5 each; imm_from_dec  in  DATA; pc_from_if  in  ADDR; is_ls_from_dec  in  1  (load/store).
REQ-006 rs1_to_reg, rs2_to_reg  out  5  combinational copies of rs1/rs2_from_dec.
REQ-007 Q1/Q2_from_reg  in  ROB_ID; V1/V2_from_reg  in  DATA  regfile rename tag and value.
REQ-008 Q1/Q2_to_rob  out  ROB_ID  combinational copies of Q1/Q2_from_reg; Q1/Q2_ready_from_rob  in  1; V1/V2_from_rob  in  DATA  ROB-held result.
REQ-009 rob_id_from_rob  in  ROB_ID  next free ROB entry id.
REQ-010 rs cdb (valid_from_rs_cdb 1, rob_id_from_rs_cdb ROB_ID, result_from_rs_cdb DATA) and ls cdb (same triple, _ls_) inputs.
REQ-011 ena_to_rs, ena_to_lsb, ena_to_rob, ena_to_reg  out  1  registered one-cycle enables.
REQ-012 openum_out, V1_out, V2_out, Q1_out, Q2_out, pc_out, imm_out, rob_id_out  out  registered payload shared by RS/LSB/ROB.
REQ-013 rd_to_rob, rd_to_reg  out  5; rob_id_to_reg  out  ROB_ID  registered.
REQ-014 commit_jump_flag_from_rob  in  1  mispredict flush.

Function
REQ-015 Latency: instruction sampled at edge t SHALL appear on all outputs after edge t, valid for exactly one cycle.
REQ-016 On ena_from_if: ena_to_rob=1; ena_to_lsb=is_ls_from_dec; ena_to_rs=!is_ls_from_dec; ena_to_reg=(rd_from_dec!=0); rob_id_out=rob_id_to_reg=rob_id_from_rob.
REQ-017 Cycle without ena_from_if: all ena_* SHALL be 0, openum_out=`OPENUM_NOP`; other payload may hold.
REQ-018 Operand resolution (per operand, first match wins): rsN==0 -> Q=0,V=0; bypass hit (REQ-019) -> Q=last_rob_id,V=0; Q_from_reg==0 -> Q=0,V=V_from_reg; rs cdb valid && tag match -> Q=0,V=rs result; ls cdb valid && tag match -> Q=0,V=ls result; ready_from_rob -> Q=0,V=V_from_rob; else Q=Q_from_reg,V=0.
REQ-019 Bypass register {last_valid, last_rd, last_rob_id} SHALL load on every edge: last_valid=ena_from_if&&rd!=0; hit when last_valid && rsN==last_rd (regfile not yet renamed).
REQ-020 Back-to-back dispatch every cycle SHALL be supported with no bubble.
REQ-021 IF SHALL assert ena_from_if only when RS, LSB and ROB are not full; dispatcher does not re-check fullness.
REQ-022 commit_jump_flag_from_rob=1 at edge: all ena_* cleared, last_valid=0, incoming instruction discarded; has priority over ena_from_if.
REQ-023 Same-cycle rs and ls cdb match on same tag cannot occur; rs cdb SHALL win if it does.

Reset
REQ-024 rst at edge: all ena_*=0, openum_out=`OPENUM_NOP`, all Q/rob_id outputs=`ZERO_ROB`, all V/pc/imm/rd outputs=0, last_valid=0; rst has priority over flush and ena_from_if.
REQ-025 rst asserted mid-stream SHALL discard the instruction sampled that edge; first post-reset dispatch SHALL see no bypass hit.

Verification
REQ-026 ADD rd=5 rs1=1 rs2=2, reg Q=0 V1=10 V2=20, rob_id 3 -> next cycle ena_to_rs=1, ena_to_rob=1, ena_to_reg=1, V1/V2=10/20, Q=0, rob_id_out=3.
REQ-027 rs1=1 Q1_from_reg=4 with rs cdb valid tag 4 result 0x55 same cycle -> Q1_out=0, V1_out=0x55; with no cdb and ready_from_rob=1 V=7 -> Q1_out=0, V1_out=7.
REQ-028 Back-to-back: A rd=6 rob 2, then B rs1=6 with Q1_from_reg=0 -> B's Q1_out=2; A with rd=0 -> B Q1_out=0, V1_out=V1_from_reg.
REQ-029 LW dispatch -> ena_to_lsb=1, ena_to_rs=0; rs1=0 -> Q1_out=0, V1_out=0 regardless of regfile.
REQ-030 Flush asserted with ena_from_if=1 -> all ena_* 0 next cycle; following instruction reading former rd gets no bypass hit.
REQ-031 rst held 2 cycles with ena_from_if=1 -> outputs at reset values, openum_out=NOP throughout.

Source files
------------

// File: rtl/dispatcher.sv
// dispatcher: resolves operands for a decoded instruction and issues it to RS/LSB/ROB/regfile one cycle later
`ifndef DISPATCHER_DEFINES
`define DISPATCHER_DEFINES
`define DATA_TYPE 31:0
`define ADDR_TYPE 31:0
`define ROB_ID_TYPE 3:0
`define OPENUM_TYPE 5:0
`define ZERO_ROB 4'd0
`define OPENUM_NOP 6'd0
`endif
module dispatcher (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena_from_if,
  input  logic [`OPENUM_TYPE] openum_from_dec,
  input  logic [4:0]          rd_from_dec,
  input  logic [4:0]          rs1_from_dec,
  input  logic [4:0]          rs2_from_dec,
  input  logic [`DATA_TYPE]   imm_from_dec,
  input  logic [`ADDR_TYPE]   pc_from_if,
  input  logic                is_ls_from_dec,
  output logic [4:0]          rs1_to_reg,
  output logic [4:0]          rs2_to_reg,
  input  logic [`ROB_ID_TYPE] Q1_from_reg,
  input  logic [`ROB_ID_TYPE] Q2_from_reg,
  input  logic [`DATA_TYPE]   V1_from_reg,
  input  logic [`DATA_TYPE]   V2_from_reg,
  output logic [`ROB_ID_TYPE] Q1_to_rob,
  output logic [`ROB_ID_TYPE] Q2_to_rob,
  input  logic                Q1_ready_from_rob,
  input  logic                Q2_ready_from_rob,
  input  logic [`DATA_TYPE]   V1_from_rob,
  input  logic [`DATA_TYPE]   V2_from_rob,
  input  logic [`ROB_ID_TYPE] rob_id_from_rob,
  input  logic                valid_from_rs_cdb,
  input  logic [`ROB_ID_TYPE] rob_id_from_rs_cdb,
  input  logic [`DATA_TYPE]   result_from_rs_cdb,
  input  logic                valid_from_ls_cdb,
  input  logic [`ROB_ID_TYPE] rob_id_from_ls_cdb,
  input  logic [`DATA_TYPE]   result_from_ls_cdb,
  output logic                ena_to_rs,
  output logic                ena_to_lsb,
  output logic                ena_to_rob,
  output logic                ena_to_reg,
  output logic [`OPENUM_TYPE] openum_out,
  output logic [`DATA_TYPE]   V1_out,
  output logic [`DATA_TYPE]   V2_out,
  output logic [`ROB_ID_TYPE] Q1_out,
  output logic [`ROB_ID_TYPE] Q2_out,
  output logic [`ADDR_TYPE]   pc_out,
  output logic [`DATA_TYPE]   imm_out,
  output logic [`ROB_ID_TYPE] rob_id_out,
  output logic [4:0]          rd_to_rob,
  output logic [4:0]          rd_to_reg,
  output logic [`ROB_ID_TYPE] rob_id_to_reg,
  input  logic                commit_jump_flag_from_rob
);
  typedef struct packed {
    logic [`ROB_ID_TYPE] q;
    logic [`DATA_TYPE]   v;
  } opnd_t;
  logic                ena_rs_q, ena_rs_d, ena_lsb_q, ena_lsb_d, ena_rob_q, ena_rob_d, ena_reg_q, ena_reg_d;
  logic [`OPENUM_TYPE] op_q, op_d;
  opnd_t               o1_q, o1_d, o2_q, o2_d;
  logic [`ADDR_TYPE]   pc_q, pc_d;
  logic [`DATA_TYPE]   imm_q, imm_d;
  logic [`ROB_ID_TYPE] rob_id_q, rob_id_d;
  logic [4:0]          rd_q, rd_d;
  logic                last_valid_q, last_valid_d;
  logic [4:0]          last_rd_q, last_rd_d;
  logic [`ROB_ID_TYPE] last_rob_id_q, last_rob_id_d;
  assign rs1_to_reg    = rs1_from_dec;
  assign rs2_to_reg    = rs2_from_dec;
  assign Q1_to_rob     = Q1_from_reg;
  assign Q2_to_rob     = Q2_from_reg;
  assign ena_to_rs     = ena_rs_q;
  assign ena_to_lsb    = ena_lsb_q;
  assign ena_to_rob    = ena_rob_q;
  assign ena_to_reg    = ena_reg_q;
  assign openum_out    = op_q;
  assign Q1_out        = o1_q.q;
  assign V1_out        = o1_q.v;
  assign Q2_out        = o2_q.q;
  assign V2_out        = o2_q.v;
  assign pc_out        = pc_q;
  assign imm_out       = imm_q;
  assign rob_id_out    = rob_id_q;
  assign rob_id_to_reg = rob_id_q;
  assign rd_to_rob     = rd_q;
  assign rd_to_reg     = rd_q;
  // Priority chain: x0, the previous dispatch not yet visible in the regfile, then committed value, cdb forwards, ROB-held result
  function automatic opnd_t resolve(input logic [4:0] rs, input logic [`ROB_ID_TYPE] q,
                                    input logic [`DATA_TYPE] v_reg, input logic rdy, input logic [`DATA_TYPE] v_rob);
    opnd_t r;
    r = (rs == 5'd0) ? '{`ZERO_ROB, '0} :
        (last_valid_q && rs == last_rd_q) ? '{last_rob_id_q, '0} :
        (q == `ZERO_ROB) ? '{`ZERO_ROB, v_reg} :
        (valid_from_rs_cdb && rob_id_from_rs_cdb == q) ? '{`ZERO_ROB, result_from_rs_cdb} :
        (valid_from_ls_cdb && rob_id_from_ls_cdb == q) ? '{`ZERO_ROB, result_from_ls_cdb} :
        rdy ? '{`ZERO_ROB, v_rob} : '{q, '0};
    return r;
  endfunction
  // Next dispatch state: a flush drops the incoming instruction and forgets the bypass entry
  always_comb begin
    ena_rs_d      = 1'b0;
    ena_lsb_d     = 1'b0;
    ena_rob_d     = 1'b0;
    ena_reg_d     = 1'b0;
    op_d          = `OPENUM_NOP;
    o1_d          = o1_q;
    o2_d          = o2_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    rob_id_d      = rob_id_q;
    rd_d          = rd_q;
    last_valid_d  = 1'b0;
    last_rd_d     = rd_from_dec;
    last_rob_id_d = rob_id_from_rob;
    if (ena_from_if && !commit_jump_flag_from_rob) begin
      ena_rs_d     = !is_ls_from_dec;
      ena_lsb_d    = is_ls_from_dec;
      ena_rob_d    = 1'b1;
      ena_reg_d    = rd_from_dec != 5'd0;
      op_d         = openum_from_dec;
      o1_d         = resolve(rs1_from_dec, Q1_from_reg, V1_from_reg, Q1_ready_from_rob, V1_from_rob);
      o2_d         = resolve(rs2_from_dec, Q2_from_reg, V2_from_reg, Q2_ready_from_rob, V2_from_rob);
      pc_d         = pc_from_if;
      imm_d        = imm_from_dec;
      rob_id_d     = rob_id_from_rob;
      rd_d         = rd_from_dec;
      last_valid_d = rd_from_dec != 5'd0;
    end
  end
  // Output and bypass registers; reset overrides flush and dispatch
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_rs_q      <= 1'b0;
      ena_lsb_q     <= 1'b0;
      ena_rob_q     <= 1'b0;
      ena_reg_q     <= 1'b0;
      op_q          <= `OPENUM_NOP;
      o1_q          <= '{`ZERO_ROB, '0};
      o2_q          <= '{`ZERO_ROB, '0};
      pc_q          <= '0;
      imm_q         <= '0;
      rob_id_q      <= `ZERO_ROB;
      rd_q          <= '0;
      last_valid_q  <= 1'b0;
      last_rd_q     <= '0;
      last_rob_id_q <= `ZERO_ROB;
    end else begin
      ena_rs_q      <= ena_rs_d;
      ena_lsb_q     <= ena_lsb_d;
      ena_rob_q     <= ena_rob_d;
      ena_reg_q     <= ena_reg_d;
      op_q          <= op_d;
      o1_q          <= o1_d;
      o2_q          <= o2_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      rob_id_q      <= rob_id_d;
      rd_q          <= rd_d;
      last_valid_q  <= last_valid_d;
      last_rd_q     <= last_rd_d;
      last_rob_id_q <= last_rob_id_d;
    end
  end
endmodule

// File: tb/tb_dispatcher.sv
// tb_dispatcher: directed scoreboard bench for the dispatcher
`ifndef DISPATCHER_DEFINES
`define DISPATCHER_DEFINES
`define DATA_TYPE 31:0
`define ADDR_TYPE 31:0
`define ROB_ID_TYPE 3:0
`define OPENUM_TYPE 5:0
`define ZERO_ROB 4'd0
`define OPENUM_NOP 6'd0
`endif
module tb_dispatcher;
  logic clk = 1'b0;
  logic rst, ena_from_if, is_ls_from_dec, commit_jump_flag_from_rob;
  logic [5:0] openum_from_dec;
  logic [4:0] rd_from_dec, rs1_from_dec, rs2_from_dec, rs1_to_reg, rs2_to_reg, rd_to_rob, rd_to_reg;
  logic [31:0] imm_from_dec, pc_from_if, V1_from_reg, V2_from_reg, V1_from_rob, V2_from_rob;
  logic [31:0] result_from_rs_cdb, result_from_ls_cdb, V1_out, V2_out, pc_out, imm_out;
  logic [3:0] Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob, rob_id_from_rob, rob_id_from_rs_cdb, rob_id_from_ls_cdb;
  logic [3:0] Q1_out, Q2_out, rob_id_out, rob_id_to_reg;
  logic Q1_ready_from_rob, Q2_ready_from_rob, valid_from_rs_cdb, valid_from_ls_cdb;
  logic ena_to_rs, ena_to_lsb, ena_to_rob, ena_to_reg;
  logic [5:0] openum_out;
  int n_pass = 0, n_total = 0;
  typedef struct {
    logic rs, lsb, rob, rg;
    logic [5:0] op;
    logic [3:0] q1, q2, rid;
    logic [31:0] v1, v2, pc, imm;
    logic [4:0] rd;
    bit pl;
  } exp_t;
  exp_t sb[$];
  localparam logic [5:0] ADD = 6'd1, LW = 6'd2, SUB = 6'd3;
  dispatcher dut (
    .clk(clk), .rst(rst), .ena_from_if(ena_from_if), .openum_from_dec(openum_from_dec),
    .rd_from_dec(rd_from_dec), .rs1_from_dec(rs1_from_dec), .rs2_from_dec(rs2_from_dec),
    .imm_from_dec(imm_from_dec), .pc_from_if(pc_from_if), .is_ls_from_dec(is_ls_from_dec),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg), .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg), .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
    .V1_from_rob(V1_from_rob), .V2_from_rob(V2_from_rob), .rob_id_from_rob(rob_id_from_rob),
    .valid_from_rs_cdb(valid_from_rs_cdb), .rob_id_from_rs_cdb(rob_id_from_rs_cdb), .result_from_rs_cdb(result_from_rs_cdb),
    .valid_from_ls_cdb(valid_from_ls_cdb), .rob_id_from_ls_cdb(rob_id_from_ls_cdb), .result_from_ls_cdb(result_from_ls_cdb),
    .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb), .ena_to_rob(ena_to_rob), .ena_to_reg(ena_to_reg),
    .openum_out(openum_out), .V1_out(V1_out), .V2_out(V2_out), .Q1_out(Q1_out), .Q2_out(Q2_out),
    .pc_out(pc_out), .imm_out(imm_out), .rob_id_out(rob_id_out), .rd_to_rob(rd_to_rob), .rd_to_reg(rd_to_reg),
    .rob_id_to_reg(rob_id_to_reg), .commit_jump_flag_from_rob(commit_jump_flag_from_rob)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask
  task automatic clr();
    ena_from_if = 0; commit_jump_flag_from_rob = 0; is_ls_from_dec = 0;
    openum_from_dec = ADD; rd_from_dec = 0; rs1_from_dec = 0; rs2_from_dec = 0;
    imm_from_dec = 0; pc_from_if = 0; rob_id_from_rob = 0;
    Q1_from_reg = 0; Q2_from_reg = 0; V1_from_reg = 0; V2_from_reg = 0;
    Q1_ready_from_rob = 0; Q2_ready_from_rob = 0; V1_from_rob = 0; V2_from_rob = 0;
    valid_from_rs_cdb = 0; rob_id_from_rs_cdb = 0; result_from_rs_cdb = 0;
    valid_from_ls_cdb = 0; rob_id_from_ls_cdb = 0; result_from_ls_cdb = 0;
  endtask
  task automatic ins(input logic [5:0] op, input logic [4:0] rd, rs1, rs2, input logic ls,
                     input logic [3:0] rid, input logic [31:0] pc, imm);
    ena_from_if = 1; openum_from_dec = op; rd_from_dec = rd; rs1_from_dec = rs1; rs2_from_dec = rs2;
    is_ls_from_dec = ls; rob_id_from_rob = rid; pc_from_if = pc; imm_from_dec = imm;
  endtask
  task automatic tick();
    exp_t e;
    #1;
    chk("rs1_to_reg", 32'(rs1_to_reg), 32'(rs1_from_dec));
    chk("Q2_to_rob", 32'(Q2_to_rob), 32'(Q2_from_reg));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("ena_to_rs", 32'(ena_to_rs), 32'(e.rs));
      chk("ena_to_lsb", 32'(ena_to_lsb), 32'(e.lsb));
      chk("ena_to_rob", 32'(ena_to_rob), 32'(e.rob));
      chk("ena_to_reg", 32'(ena_to_reg), 32'(e.rg));
      chk("openum_out", 32'(openum_out), 32'(e.op));
      if (e.pl) begin
        chk("Q1_out", 32'(Q1_out), 32'(e.q1));
        chk("V1_out", V1_out, e.v1);
        chk("Q2_out", 32'(Q2_out), 32'(e.q2));
        chk("V2_out", V2_out, e.v2);
        chk("rob_id_out", 32'(rob_id_out), 32'(e.rid));
        chk("rob_id_to_reg", 32'(rob_id_to_reg), 32'(e.rid));
        chk("pc_out", pc_out, e.pc);
        chk("imm_out", imm_out, e.imm);
        chk("rd_to_rob", 32'(rd_to_rob), 32'(e.rd));
        chk("rd_to_reg", 32'(rd_to_reg), 32'(e.rd));
      end
    end
  endtask
  initial begin
    exp_t rst_e, nop_e;
    rst_e = '{0, 0, 0, 0, 6'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1};
    nop_e = '{0, 0, 0, 0, 6'd0, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0};
    clr();
    rst = 1;
    ins(ADD, 1, 2, 3, 0, 9, 32'h40, 32'h4);
    V1_from_reg = 1; V2_from_reg = 2;
    sb.push_back(rst_e); tick();
    sb.push_back(rst_e); tick();
    clr(); rst = 0;
    ins(ADD, 5, 1, 2, 0, 3, 32'h100, 32'h0);
    V1_from_reg = 10; V2_from_reg = 20;
    sb.push_back('{1, 0, 1, 1, ADD, 4'd0, 4'd0, 4'd3, 32'd10, 32'd20, 32'h100, 32'h0, 5'd5, 1'b1}); tick();
    clr();
    ins(SUB, 0, 1, 2, 0, 4, 32'h104, 32'h8);
    Q1_from_reg = 4; valid_from_rs_cdb = 1; rob_id_from_rs_cdb = 4; result_from_rs_cdb = 32'h55;
    valid_from_ls_cdb = 1; rob_id_from_ls_cdb = 4; result_from_ls_cdb = 32'h99; V2_from_reg = 20;
    sb.push_back('{1, 0, 1, 0, SUB, 4'd0, 4'd0, 4'd4, 32'h55, 32'd20, 32'h104, 32'h8, 5'd0, 1'b1}); tick();
    clr();
    ins(ADD, 7, 1, 3, 0, 5, 32'h108, 32'h0);
    Q1_from_reg = 4; Q1_ready_from_rob = 1; V1_from_rob = 7; Q2_from_reg = 6; V2_from_rob = 32'h33;
    sb.push_back('{1, 0, 1, 1, ADD, 4'd0, 4'd6, 4'd5, 32'd7, 32'd0, 32'h108, 32'h0, 5'd7, 1'b1}); tick();
    clr();
    ins(ADD, 6, 2, 7, 0, 2, 32'h10c, 32'h0);
    Q1_from_reg = 5; valid_from_ls_cdb = 1; rob_id_from_ls_cdb = 5; result_from_ls_cdb = 32'hAA;
    valid_from_rs_cdb = 1; rob_id_from_rs_cdb = 9; result_from_rs_cdb = 32'h11; V2_from_reg = 123;
    sb.push_back('{1, 0, 1, 1, ADD, 4'd0, 4'd5, 4'd2, 32'hAA, 32'd0, 32'h10c, 32'h0, 5'd6, 1'b1}); tick();
    clr();
    ins(LW, 0, 6, 0, 1, 7, 32'h110, 32'h10);
    V1_from_reg = 77; Q2_from_reg = 3; V2_from_reg = 999;
    sb.push_back('{0, 1, 1, 0, LW, 4'd2, 4'd0, 4'd7, 32'd0, 32'd0, 32'h110, 32'h10, 5'd0, 1'b1}); tick();
    clr();
    ins(ADD, 9, 6, 0, 0, 8, 32'h114, 32'h0);
    V1_from_reg = 77;
    sb.push_back('{1, 0, 1, 1, ADD, 4'd0, 4'd0, 4'd8, 32'd77, 32'd0, 32'h114, 32'h0, 5'd9, 1'b1}); tick();
    clr();
    ins(LW, 10, 0, 9, 1, 9, 32'h118, 32'hFFFF_FFFC);
    Q1_from_reg = 3; V1_from_reg = 5; V2_from_reg = 44;
    sb.push_back('{0, 1, 1, 1, LW, 4'd0, 4'd8, 4'd9, 32'd0, 32'd0, 32'h118, 32'hFFFF_FFFC, 5'd10, 1'b1}); tick();
    clr();
    sb.push_back(nop_e); tick();
    clr();
    ins(ADD, 11, 0, 0, 0, 10, 32'h11c, 32'h0);
    commit_jump_flag_from_rob = 1;
    sb.push_back(nop_e); tick();
    clr();
    ins(ADD, 0, 11, 0, 0, 11, 32'h200, 32'h0);
    V1_from_reg = 33;
    sb.push_back('{1, 0, 1, 0, ADD, 4'd0, 4'd0, 4'd11, 32'd33, 32'd0, 32'h200, 32'h0, 5'd0, 1'b1}); tick();
    clr();
    ins(ADD, 12, 0, 0, 0, 12, 32'h204, 32'h0);
    sb.push_back('{1, 0, 1, 1, ADD, 4'd0, 4'd0, 4'd12, 32'd0, 32'd0, 32'h204, 32'h0, 5'd12, 1'b1}); tick();
    clr(); rst = 1;
    ins(ADD, 13, 12, 12, 0, 13, 32'h208, 32'h4);
    sb.push_back(rst_e); tick();
    clr(); rst = 0;
    ins(ADD, 1, 12, 13, 0, 14, 32'h300, 32'h0);
    V1_from_reg = 8; V2_from_reg = 9;
    sb.push_back('{1, 0, 1, 1, ADD, 4'd0, 4'd0, 4'd14, 32'd8, 32'd9, 32'h300, 32'h0, 5'd1, 1'b1}); tick();
    clr();
    sb.push_back(nop_e); tick();
    n_total++;
    assert (sb.size() == 0) n_pass++;
    else $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
